// File: rtl/valid_flush_ctrl_pkg.sv
// Shared types for the valid-array flush controller.
// Holds the flush FSM state encoding and a small helper that classifies
// which states count as "flush in progress" for the busy indicator.
package rv32i_types;

  // Flush controller states. IDLE is the pass-through state; everything
  // else owns the valid arrays and stalls the cache controller.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    SWEEP     = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } flush_state_t;

  // Busy covers waiting for the controller, the sweep itself and the
  // drain cycle. DONE is excluded so busy falls as flush_done rises.
  function automatic logic state_is_busy(input flush_state_t s);
    return (s == WAIT_IDLE) || (s == SWEEP) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/valid_flush_ctrl_if.sv
// Bundle of the flush request, the cache controller's valid-array port,
// the muxed valid-array port and the flush status signals.
// master = cache controller side, slave = flush controller side.
interface valid_flush_ctrl_if #(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4
);

  // Flush request and controller status
  logic               flush_req;
  logic               ctrl_idle;

  // Controller's own valid-array request (active-low selects/enables)
  logic [WAYS-1:0]    ctrl_csb;
  logic [WAYS-1:0]    ctrl_web;
  logic [S_INDEX-1:0] ctrl_addr;
  logic [WAYS-1:0]    ctrl_din;

  // Port actually driven into the per-way valid arrays
  logic [WAYS-1:0]    va_csb;
  logic [WAYS-1:0]    va_web;
  logic [S_INDEX-1:0] va_addr;
  logic [WAYS-1:0]    va_din;

  // Status back to the controller
  logic               ctrl_stall;
  logic               flush_busy;
  logic               flush_done;

  modport master (
    output flush_req, ctrl_idle, ctrl_csb, ctrl_web, ctrl_addr, ctrl_din,
    input  va_csb, va_web, va_addr, va_din,
    input  ctrl_stall, flush_busy, flush_done
  );

  modport slave (
    input  flush_req, ctrl_idle, ctrl_csb, ctrl_web, ctrl_addr, ctrl_din,
    output va_csb, va_web, va_addr, va_din,
    output ctrl_stall, flush_busy, flush_done
  );

endinterface

// File: rtl/valid_array.sv
// One way's valid-bit array: NUM_SETS single-bit entries, registered
// write and registered read, cleared by its own asynchronous reset.
// Not part of the flush controller; one copy per way sits on va_*.
module valid_array #(
  parameter int S_INDEX = 4
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               csb0,
  input  logic               web0,
  input  logic [S_INDEX-1:0] addr0,
  input  logic               din0,
  output logic               dout0
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  logic [NUM_SETS-1:0] valid_reg;

  // Selected write lands at the edge; selected read returns next cycle.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      valid_reg <= '0;
      dout0     <= 1'b0;
    end else if (!csb0) begin
      if (!web0) begin
        valid_reg[addr0] <= din0;
      end else begin
        dout0 <= valid_reg[addr0];
      end
    end
  end

endmodule

// File: rtl/valid_flush_ctrl.sv
// Valid-array flush controller.
// While idle the cache controller's valid-array requests pass straight
// through. On a flush request it waits for the controller to go idle,
// then writes 0 to every set of every way, one set per cycle, allows one
// drain cycle for the arrays' registered write, and pulses flush_done.
// Requests arriving while a flush is in progress are remembered and
// trigger another complete flush right after the current one.
module valid_flush_ctrl
  import rv32i_types::*;
#(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4
) (
  input  logic           clk0,
  input  logic           rst0,
  valid_flush_ctrl_if.slave bus
);

  localparam int                 NUM_SETS = 2 ** S_INDEX;
  localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

  flush_state_t       state_reg,   state_next;
  logic [S_INDEX-1:0] cnt_reg,     cnt_next;
  logic               pending_reg, pending_next;

  // State, sweep counter and pending flag; reset abandons any flush.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state logic: sequencing, sweep counting and request capture.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;

    // A request seen while not idle must not be lost; it is replayed
    // as a fresh flush once the current one reaches DONE.
    if ((state_reg != IDLE) && bus.flush_req) begin
      pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.flush_req) begin
          state_next = bus.ctrl_idle ? SWEEP : WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        cnt_next = '0;
        if (bus.ctrl_idle) begin
          state_next = SWEEP;
        end
      end

      SWEEP: begin
        // Runs to completion regardless of ctrl_idle; the counter wraps
        // back to 0 as the last set is written.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_SET) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        state_next = DONE;
      end

      DONE: begin
        // A request arriving in this very cycle is treated the same as
        // one captured earlier, so it is never dropped.
        if (pending_reg || bus.flush_req) begin
          pending_next = 1'b0;
          state_next   = WAIT_IDLE;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        pending_next = 1'b0;
      end
    endcase
  end

  // Output mux: pass-through in IDLE, clear-write in SWEEP, hold arrays
  // deselected in every other state.
  always_comb begin
    bus.va_csb     = '1;
    bus.va_web     = '1;
    bus.va_addr    = '0;
    bus.va_din     = '0;
    bus.ctrl_stall = 1'b1;
    bus.flush_busy = state_is_busy(state_reg);
    bus.flush_done = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.va_csb     = bus.ctrl_csb;
        bus.va_web     = bus.ctrl_web;
        bus.va_addr    = bus.ctrl_addr;
        bus.va_din     = bus.ctrl_din;
        bus.ctrl_stall = 1'b0;
      end

      SWEEP: begin
        bus.va_csb  = '0;
        bus.va_web  = '0;
        bus.va_din  = '0;
        bus.va_addr = cnt_reg;
      end

      DONE: begin
        bus.flush_done = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_valid_flush_ctrl.sv
// Testbench for valid_flush_ctrl with four valid_array copies on va_*.
// A reference array of valid bits tracks what the arrays should hold;
// flush timing is predicted arithmetically from the request cycle, the
// number of cycles the controller stays busy and any second request.
module tb_valid_flush_ctrl;

  localparam int S_INDEX  = 4;
  localparam int WAYS     = 4;
  localparam int NUM_SETS = 2 ** S_INDEX;

  logic clk0;
  logic rst0;
  logic [WAYS-1:0] dout;

  int checks = 0;
  int errors = 0;

  bit model_v [WAYS][NUM_SETS];

  valid_flush_ctrl_if #(.S_INDEX(S_INDEX), .WAYS(WAYS)) vif ();

  valid_flush_ctrl #(.S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
    .clk0 (clk0),
    .rst0 (rst0),
    .bus  (vif)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_va
      valid_array #(.S_INDEX(S_INDEX)) u_va (
        .clk0  (clk0),
        .rst0  (rst0),
        .csb0  (vif.va_csb[gi]),
        .web0  (vif.va_web[gi]),
        .addr0 (vif.va_addr),
        .din0  (vif.va_din[gi]),
        .dout0 (dout[gi])
      );
    end
  endgenerate

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < NUM_SETS; s++)
        model_v[w][s] = 1'b0;
  endtask

  task automatic drive_ctrl(input logic [WAYS-1:0] csb, input logic [WAYS-1:0] web,
                            input logic [S_INDEX-1:0] addr, input logic [WAYS-1:0] din);
    vif.ctrl_csb  = csb;
    vif.ctrl_web  = web;
    vif.ctrl_addr = addr;
    vif.ctrl_din  = din;
  endtask

  // Pass-through expectations against the values the bench just drove.
  task automatic chk_pass(input string tag, input logic [WAYS-1:0] csb, input logic [WAYS-1:0] web,
                          input logic [S_INDEX-1:0] addr, input logic [WAYS-1:0] din);
    check({tag, "_csb"},   vif.va_csb,     csb);
    check({tag, "_web"},   vif.va_web,     web);
    check({tag, "_addr"},  vif.va_addr,    addr);
    check({tag, "_din"},   vif.va_din,     din);
    check({tag, "_stall"}, vif.ctrl_stall, 1'b0);
    check({tag, "_busy"},  vif.flush_busy, 1'b0);
    check({tag, "_done"},  vif.flush_done, 1'b0);
  endtask

  // One controller access in IDLE; reads are checked against the model.
  task automatic ctrl_access(input string tag, input logic [WAYS-1:0] csb, input logic [WAYS-1:0] web,
                             input logic [S_INDEX-1:0] addr, input logic [WAYS-1:0] din);
    drive_ctrl(csb, web, addr, din);
    #1;
    chk_pass(tag, csb, web, addr, din);
    tick();
    for (int w = 0; w < WAYS; w++) begin
      if (!csb[w] && web[w])
        check($sformatf("%s_rd_w%0d_s%0d", tag, w, addr), dout[w], model_v[w][addr]);
      if (!csb[w] && !web[w])
        model_v[w][addr] = din[w];
    end
    $display("access %s csb=%b web=%b addr=%0d din=%b", tag, csb, web, addr, din);
    drive_ctrl('1, '1, '0, '0);
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < NUM_SETS; s++)
      ctrl_access(tag, '0, '1, S_INDEX'(s), '0);
  endtask

  task automatic random_accesses(input string tag, input int n);
    for (int i = 0; i < n; i++)
      ctrl_access(tag, WAYS'($urandom), WAYS'($urandom), S_INDEX'($urandom), WAYS'($urandom));
  endtask

  // Flush requested at cycle 0 with the controller busy for w cycles
  // (cycles 0..w-1); optionally a second request at sweep count c.
  // Controller junk is driven throughout and must never reach the arrays.
  task automatic do_flush(input string tag, input int w, input bit second, input int c);
    int s1, d1, s2, d2, last, dones, exp_dones, exp_addr;
    bit exp_sweep, exp_done;
    s1 = w + 1;
    d1 = s1 + NUM_SETS + 1;
    s2 = d1 + 2;
    d2 = s2 + NUM_SETS + 1;
    last = second ? d2 : d1;
    exp_dones = second ? 2 : 1;
    dones = 0;

    vif.flush_req = 1'b1;
    vif.ctrl_idle = (w == 0);
    drive_ctrl('1, '1, '0, '0);
    #1;
    check({tag, "_accept_busy"}, vif.flush_busy, 1'b0);
    tick();

    for (int t = 1; t <= last; t++) begin
      vif.flush_req = second && (t == s1 + c);
      vif.ctrl_idle = (t >= w);
      drive_ctrl(WAYS'($urandom), WAYS'($urandom), S_INDEX'($urandom), WAYS'($urandom));
      exp_sweep = 1'b0;
      exp_done  = 1'b0;
      exp_addr  = 0;
      if (t >= s1 && t < s1 + NUM_SETS) begin
        exp_sweep = 1'b1;
        exp_addr  = t - s1;
      end else if (second && t >= s2 && t < s2 + NUM_SETS) begin
        exp_sweep = 1'b1;
        exp_addr  = t - s2;
      end
      if (t == d1 || (second && t == d2))
        exp_done = 1'b1;
      #1;
      check($sformatf("%s_t%0d_stall", tag, t), vif.ctrl_stall, 1'b1);
      check($sformatf("%s_t%0d_done", tag, t), vif.flush_done, exp_done);
      check($sformatf("%s_t%0d_busy", tag, t), vif.flush_busy, !exp_done);
      if (exp_sweep) begin
        check($sformatf("%s_t%0d_csb", tag, t), vif.va_csb, 4'b0000);
        check($sformatf("%s_t%0d_web", tag, t), vif.va_web, 4'b0000);
        check($sformatf("%s_t%0d_din", tag, t), vif.va_din, 4'b0000);
        check($sformatf("%s_t%0d_addr", tag, t), vif.va_addr, exp_addr);
      end else begin
        check($sformatf("%s_t%0d_csb", tag, t), vif.va_csb, 4'b1111);
      end
      if (vif.flush_done === 1'b1)
        dones++;
      tick();
    end

    vif.flush_req = 1'b0;
    vif.ctrl_idle = 1'b1;
    drive_ctrl('1, '1, '0, '0);
    #1;
    chk_pass({tag, "_back_idle"}, '1, '1, '0, '0);
    check({tag, "_done_count"}, dones, exp_dones);
    model_clear();
    $display("flush %s wait=%0d second=%0d at=%0d done_pulses=%0d", tag, w, second, c, dones);
  endtask

  initial begin
    int rw, rs, rc;

    rst0 = 1'b1;
    vif.flush_req = 1'b0;
    vif.ctrl_idle = 1'b1;
    drive_ctrl(4'b1010, 4'b0110, 4'd9, 4'b0011);
    model_clear();
    #2;
    chk_pass("reset", 4'b1010, 4'b0110, 4'd9, 4'b0011);
    tick();
    tick();
    check("reset_hold_done", vif.flush_done, 1'b0);
    drive_ctrl('1, '1, '0, '0);
    rst0 = 1'b0;

    // Every set valid in every way
    for (int s = 0; s < NUM_SETS; s++)
      ctrl_access("fill", '0, '0, S_INDEX'(s), '1);
    check_all("fill_rd");

    // Single-way write: way 2, set 5
    ctrl_access("w2s5_clr", 4'b1011, 4'b1011, 4'd5, 4'b0000);
    ctrl_access("w2s5_rd0", 4'b0000, 4'b1111, 4'd5, 4'b0000);
    ctrl_access("w2s5_set", 4'b1011, 4'b1011, 4'd5, 4'b0100);
    ctrl_access("w2s5_rd1", 4'b0000, 4'b1111, 4'd5, 4'b0000);

    // Basic flush with the controller idle
    do_flush("basic", 0, 1'b0, 0);
    check_all("basic_rd");

    // Controller busy for five cycles
    random_accesses("fill2", 40);
    do_flush("waitidle", 5, 1'b0, 0);
    check_all("waitidle_rd");

    // Second request mid-sweep at count 7
    random_accesses("fill3", 40);
    do_flush("double", 0, 1'b1, 7);
    check_all("double_rd");

    // Randomised rounds
    for (int r = 0; r < 6; r++) begin
      random_accesses($sformatf("rnd%0d", r), 24);
      rw = $urandom_range(0, 6);
      rs = $urandom_range(0, 1);
      rc = $urandom_range(0, NUM_SETS - 1);
      do_flush($sformatf("rnd%0d", r), rw, rs[0], rc);
      check_all($sformatf("rnd%0d_rd", r));
    end

    // Reset in the middle of a sweep
    for (int s = 0; s < 4; s++)
      ctrl_access("prerst", '0, '0, S_INDEX'(s), '1);
    vif.flush_req = 1'b1;
    vif.ctrl_idle = 1'b1;
    tick();
    vif.flush_req = 1'b0;
    repeat (9) tick();
    drive_ctrl(4'b0110, 4'b1100, 4'd12, 4'b1001);
    #1;
    check("rstmid_addr9", vif.va_addr, 4'd9);
    check("rstmid_busy_before", vif.flush_busy, 1'b1);
    #2;
    rst0 = 1'b1;
    #1;
    chk_pass("rstmid", 4'b0110, 4'b1100, 4'd12, 4'b1001);
    model_clear();
    tick();
    check("rstmid_hold_done", vif.flush_done, 1'b0);
    check("rstmid_hold_stall", vif.ctrl_stall, 1'b0);
    tick();
    rst0 = 1'b0;
    drive_ctrl('1, '1, '0, '0);
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("postrst_done_%0d", i), vif.flush_done, 1'b0);
      check($sformatf("postrst_busy_%0d", i), vif.flush_busy, 1'b0);
      tick();
    end
    $display("reset mid-sweep at count 9 applied");
    check_all("postrst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
